div_seq: RTL and testbench
==========================

# div_seq

Sequencer between the CPU control unit and the 32-iteration unsigned divider core. It handles MIPS DIV and DIVU. It captures operands, converts signed operands to magnitudes and drives the core's go/ok handshake. It then applies sign fixup, writes the architectural HI/LO registers and reports completion or divide-by-zero back to control. It also owns MTHI/MTLO writes, so HI/LO have a single writer.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request for a divide; sampled only in IDLE
- is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start
- rs_val  in  32  dividend; sampled with start
- rt_val  in  32  divisor; sampled with start
- mthi_we / mtlo_we  in  1  write wdata to HI / LO; honoured only in IDLE with start=0
- wdata  in  32  MTHI/MTLO data
- core_go  out  1  divControl to core; combinational
- core_a / core_b  out  32  magnitude operands to core; registered
- core_q / core_r  in  32  core quotient / remainder
- core_ok  in  1  core idle/ready flag (low while iterating)
- hi / lo  out  32  architectural HI (remainder) / LO (quotient); reset 0
- busy  out  1  state != IDLE; reset 0
- done  out  1  registered one-cycle pulse, coincident with first cycle HI/LO show the new result; reset 0
- div_zero  out  1  registered pulse with done when divisor was 0; reset 0

## Operation
- States: IDLE, ARM, RUN, FIX.
- IDLE, start=1, rt_val!=0:
  - Latch sign flags: neg_q = is_signed & (rs[31]^rt[31]); neg_r = is_signed & rs[31].
  - core_a = |rs| if signed else rs; core_b likewise from rt. Two's-complement negation; |0x80000000| = 0x80000000 unsigned.
  - Next state ARM.
- IDLE, start=1, rt_val==0: no core launch, HI/LO unchanged; next cycle done=1 and div_zero=1; stay IDLE.
- IDLE, start=0: mthi_we/mtlo_we write HI/LO at the edge. Both may be asserted together; both registers are written.
- ARM: core_go=1 until core_ok==0 is seen, then RUN.
- RUN: core_go = ~core_ok. When core_ok==1, register core_q/core_r into internal q/r and go to FIX. core_go is already 0 in that cycle, so the core does not restart.
- FIX:
  - lo <= neg_q ? -q : q; hi <= neg_r ? -r : r.
  - Set done for one cycle; return to IDLE.
- Arithmetic wraps mod 2^32. Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, with no exception.
- start, mthi_we and mtlo_we are ignored while busy. Operands are not re-sampled mid-divide.

## Timing
- Cycle 0 = IDLE with start.
- core_go is high in cycles 1–33 and low from cycle 34.
- Core latches operands at the end of cycle 1; core_ok is low in cycles 2–33 (32 iterations) and high in cycle 34.
- q/r are captured at the end of cycle 34; FIX is cycle 35.
- hi/lo updated and done=1 in cycle 36; busy is low in cycle 36.
- A new start is accepted in cycle 36.
- Divide-by-zero latency: done and div_zero in cycle 1; busy never asserts.
- Asynchronous reset at any point:
  - Forces IDLE; hi, lo, busy, done, div_zero, core_a and core_b go to 0; core_go = 0.
  - No stale done follows.
  - The core is reset by the same net.

## Test plan
- DIVU 100 / 7 -> done in cycle 36; LO=14, HI=2; div_zero=0; busy high cycles 1–35.
- DIV -100 / 7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2). DIV 100 / -7 -> LO=-14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU of the same operands -> LO=0, HI=0x80000000.
- Divide by zero: MTHI 0x1234 and MTLO 0x5678, then DIV 5 / 0 -> done=div_zero=1 in cycle 1; HI=0x1234, LO=0x5678 unchanged; core_go never asserts.
- During a divide, pulse start with new operands and assert mthi_we -> both ignored; the result reflects the original operands and HI is not overwritten.
- Assert reset in cycle 20 of a divide -> all outputs 0 immediately; no done pulse after release; a fresh DIVU 9 / 3 then completes with LO=3, HI=0 in 36 cycles.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: MIPS DIV/DIVU sequencer around a 32-iteration unsigned divider core.
// Owns HI/LO: divide results, MTHI/MTLO writes and sign fixup.
module div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] wdata,
  output logic        core_go,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic [31:0] core_q,
  input  logic [31:0] core_r,
  input  logic        core_ok,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    FIX
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] q;
  logic [31:0] r;
  logic        launch;
  logic        dz_req;

  function automatic logic [31:0] mag(
    input logic        sg,
    input logic [31:0] x
  );
    return (sg && x[31]) ? (32'd0 - x) : x;
  endfunction

  assign launch = (state == IDLE) && start && (rt_val != 32'd0);
  assign dz_req = (state == IDLE) && start && (rt_val == 32'd0);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    core_go  = 1'b0;
    unique case (state)
      IDLE: if (launch) state_nx = ARM;
      ARM: begin
        core_go = 1'b1;
        if (!core_ok) state_nx = RUN;
      end
      // go drops the same cycle ok rises so the core never relaunches
      RUN: begin
        core_go = ~core_ok;
        if (core_ok) state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_a   <= '0;
      core_b   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      q        <= '0;
      r        <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (launch) begin
        neg_q  <= is_signed & (rs_val[31] ^ rt_val[31]);
        neg_r  <= is_signed & rs_val[31];
        core_a <= mag(is_signed, rs_val);
        core_b <= mag(is_signed, rt_val);
      end
      if (dz_req) begin
        done     <= 1'b1;
        div_zero <= 1'b1;
      end
      if (state == IDLE && !start) begin
        if (mthi_we) hi <= wdata;
        if (mtlo_we) lo <= wdata;
      end
      if (state == RUN && core_ok) begin
        q <= core_q;
        r <= core_r;
      end
      if (state == FIX) begin
        lo   <= neg_q ? (32'd0 - q) : q;
        hi   <= neg_r ? (32'd0 - r) : r;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed test of div_seq with a behavioural core and a
// transaction-level HI/LO model checked every cycle.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        mthi_we = 1'b0;
  logic        mtlo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        core_go;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [31:0] core_q;
  logic [31:0] core_r;
  logic        core_ok;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int total = 0;
  int bad = 0;

  div_seq dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .rs_val(rs_val), .rt_val(rt_val), .mthi_we(mthi_we),
    .mtlo_we(mtlo_we), .wdata(wdata), .core_go(core_go),
    .core_a(core_a), .core_b(core_b), .core_q(core_q),
    .core_r(core_r), .core_ok(core_ok), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Behavioural divider core: 32 cycles of ok=0 after a go is accepted.
  logic [31:0] ca, cb;
  int          ccnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_ok <= 1'b1;
      ccnt    <= 0;
      ca      <= '0;
      cb      <= '1;
      core_q  <= '0;
      core_r  <= '0;
    end else if (core_ok && core_go) begin
      ca      <= core_a;
      cb      <= core_b;
      ccnt    <= 32;
      core_ok <= 1'b0;
    end else if (!core_ok) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1) begin
        core_ok <= 1'b1;
        core_q  <= ca / cb;
        core_r  <= ca % cb;
      end
    end
  end

  // Architectural model: a divide accepted in cycle 0 lands in cycle 36.
  logic [31:0] m_hi, m_lo, m_phi, m_plo, m_a, m_b;
  logic        m_done, m_dz;
  int          m_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_done = 0; m_dz = 0; m_cnt = 0;
    end else begin
      m_done = 0;
      m_dz = 0;
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_hi = m_phi;
          m_lo = m_plo;
          m_done = 1;
        end
      end else if (start) begin
        if (rt_val == 0) begin
          m_done = 1;
          m_dz = 1;
        end else begin
          longint sa, sb, sq, sr;
          logic [63:0] uq, ur;
          sa = is_signed ? longint'($signed(rs_val)) : longint'(rs_val);
          sb = is_signed ? longint'($signed(rt_val)) : longint'(rt_val);
          sq = sa / sb;
          sr = sa % sb;
          uq = sq;
          ur = sr;
          m_plo = uq[31:0];
          m_phi = ur[31:0];
          m_a = (is_signed && sa < 0) ? 32'(-sa) : rs_val;
          m_b = (is_signed && sb < 0) ? 32'(-sb) : rt_val;
          m_cnt = 35;
        end
      end else begin
        if (mthi_we) m_hi = wdata;
        if (mtlo_we) m_lo = wdata;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy", 32'(busy), 32'(m_cnt > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("div_zero", 32'(div_zero), 32'(m_dz));
    chk("core_go", 32'(core_go), 32'(m_cnt >= 3));
    if (m_cnt > 0) begin
      chk("core_a", core_a, m_a);
      chk("core_b", core_b, m_b);
    end
  end

  // Called at a negedge; returns at the negedge where done was seen.
  task automatic run_div(input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input bit inj,
                         output int lat, output logic dzo,
                         output logic go_seen);
    is_signed = sg;
    rs_val = a;
    rt_val = b;
    start = 1'b1;
    lat = -1;
    dzo = 1'b0;
    go_seen = 1'b0;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      if (core_go) go_seen = 1'b1;
      if (done) begin
        lat = k;
        dzo = div_zero;
      end
      start = 1'b0;
      mthi_we = 1'b0;
      if (inj && k == 5) begin
        start = 1'b1;
        is_signed = 1'b1;
        rs_val = 32'd7;
        rt_val = 32'd1;
        mthi_we = 1'b1;
        wdata = 32'hDEAD;
      end
    end
    start = 1'b0;
    mthi_we = 1'b0;
    if (lat < 0) chk("done_timeout", 32'hFFFFFFFF, 32'd36);
  endtask

  task automatic div_case(input string nm, input logic sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit inj, input logic [31:0] elo,
                          input logic [31:0] ehi);
    int   lat;
    logic dzo, gs;
    run_div(sg, a, b, inj, lat, dzo, gs);
    chk({nm, "_lat"}, 32'(lat), 32'd36);
    chk({nm, "_lo"}, lo, elo);
    chk({nm, "_hi"}, hi, ehi);
    chk({nm, "_dz"}, 32'(dzo), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   lat;
    logic dzo, gs;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    div_case("divu_100_7", 1'b0, 32'd100, 32'd7, 0, 32'd14, 32'd2);
    div_case("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 0,
             32'hFFFFFFF2, 32'hFFFFFFFE);
    div_case("div_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 0,
             32'hFFFFFFF2, 32'd2);
    div_case("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 0,
             32'h80000000, 32'd0);
    div_case("divu_big", 1'b0, 32'h80000000, 32'hFFFFFFFF, 0,
             32'd0, 32'h80000000);

    @(negedge clk);
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'hAAAA;
    @(negedge clk);
    mthi_we = 1'b0; mtlo_we = 1'b0;
    chk("mt_both_hi", hi, 32'hAAAA);
    chk("mt_both_lo", lo, 32'hAAAA);
    mthi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    mtlo_we = 1'b0;
    chk("mthi", hi, 32'h1234);
    chk("mtlo", lo, 32'h5678);

    run_div(1'b1, 32'd5, 32'd0, 0, lat, dzo, gs);
    chk("dz_lat", 32'(lat), 32'd1);
    chk("dz_flag", 32'(dzo), 32'd1);
    chk("dz_go", 32'(gs), 32'd0);
    chk("dz_hi", hi, 32'h1234);
    chk("dz_lo", lo, 32'h5678);
    @(negedge clk);
    chk("dz_done_clr", 32'(done), 32'd0);

    div_case("ignore", 1'b0, 32'd1000, 32'd10, 1, 32'd100, 32'd0);

    is_signed = 1'b0; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("ar_hi", hi, 32'd0);
    chk("ar_lo", lo, 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_dz", 32'(div_zero), 32'd0);
    chk("ar_go", 32'(core_go), 32'd0);
    chk("ar_a", core_a, 32'd0);
    chk("ar_b", core_b, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("no_stale_done", 32'(done), 32'd0);
    end

    div_case("divu_9_3", 1'b0, 32'd9, 32'd3, 0, 32'd3, 32'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
